// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak message front end: FSM states,
// padding bytes and block-geometry helpers.
package keccak_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      EMIT  = 2'd1,
      EXTRA = 2'd2
   } state_t;

   localparam logic [7:0] PAD_END  = 8'h80;
   localparam logic [7:0] DS_SHA3  = 8'h06;
   localparam logic [7:0] DS_SHAKE = 8'h1F;

   function automatic int words_per_block(input int rate, input int in_w);
      return rate / in_w;
   endfunction

   function automatic int bytes_per_word(input int in_w);
      return in_w / 8;
   endfunction

   // Index width that stays legal when a block holds a single word.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/keccak_pad_lane.sv
// One channel's rate buffer: word write with byte masking on the last beat,
// plus the domain-separation and final 0x80 pad bits.
module keccak_pad_lane
   import keccak_pkg::*;
#(
   parameter int         IN_W    = 64,
   parameter int         RATE    = 1088,
   parameter logic [7:0] DS_BYTE = DS_SHA3,
   localparam int        WPB     = words_per_block(RATE, IN_W),
   localparam int        WB      = bytes_per_word(IN_W),
   localparam int        WIDX    = idx_width(WPB),
   localparam int        NBW     = $clog2(WB) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            ld_extra,
   input  logic            wr_en,
   input  logic            wr_last,
   input  logic [WIDX-1:0] wr_idx,
   input  logic [NBW-1:0]  wr_bytes,
   input  logic [IN_W-1:0] wr_data,
   output logic [RATE-1:0] blk
);

   localparam logic [WIDX-1:0] LAST_IDX = WIDX'(WPB - 1);
   localparam logic [NBW-1:0]  FULL_NB  = NBW'(WB);

   logic [RATE-1:0] buf_q;
   logic [RATE-1:0] buf_d;
   logic [7:0]      byte_v;
   logic            full_last;
   int              j;

   assign full_last = wr_last && (wr_bytes == FULL_NB);

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      buf_d  = buf_q;
      byte_v = 8'h00;
      j      = 0;
      if (clr) begin
         buf_d = '0;
      end else if (ld_extra) begin
         buf_d                = '0;
         buf_d[7:0]           = DS_BYTE;
         buf_d[RATE-1 -: 8]   = buf_d[RATE-1 -: 8] | PAD_END;
      end else if (wr_en) begin
         for (int k = 0; k < WPB; k++) begin
            if (wr_idx == k[WIDX-1:0]) begin
               for (int b = 0; b < WB; b++) begin
                  if (!wr_last || (b[NBW-1:0] < wr_bytes)) byte_v = wr_data[b*8 +: 8];
                  else                                     byte_v = 8'h00;
                  if (wr_last && (b[NBW-1:0] == wr_bytes)) byte_v = byte_v | DS_BYTE;
                  buf_d[k*IN_W + b*8 +: 8] = byte_v;
               end
            end
         end
         // A completely full last word pushes the domain byte into the next word.
         for (int k = 1; k < WPB; k++) begin
            j = k - 1;
            if (full_last && (wr_idx == j[WIDX-1:0]))
               buf_d[k*IN_W +: 8] = buf_d[k*IN_W +: 8] | DS_BYTE;
         end
         if (wr_last && !(full_last && (wr_idx == LAST_IDX)))
            buf_d[RATE-1 -: 8] = buf_d[RATE-1 -: 8] | PAD_END;
      end
   end

   // NOTE: the buffer is reset because unwritten bytes of a block must read as zero.
   // NOTE: sequential state uses non-blocking assignment so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) buf_q <= '0;
      else        buf_q <= buf_d;
   end

   assign blk = buf_q;

endmodule

// File: rtl/keccak_pad_packer.sv
// Multi-channel SHA-3 message packer: shared handshake FSM and word counter
// driving one padding lane per channel.
module keccak_pad_packer
   import keccak_pkg::*;
#(
   parameter int         NUM_CH  = 2,
   parameter int         IN_W    = 64,
   parameter int         RATE    = 1088,
   parameter logic [7:0] DS_BYTE = DS_SHA3,
   localparam int        WPB     = words_per_block(RATE, IN_W),
   localparam int        WB      = bytes_per_word(IN_W),
   localparam int        WIDX    = idx_width(WPB),
   localparam int        NBW     = $clog2(WB) + 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic                   i_last,
   input  logic [NBW-1:0]         i_bytes,
   input  logic [NUM_CH*IN_W-1:0] i_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [NUM_CH*RATE-1:0] o_block,
   output logic                   o_final
);

   localparam logic [WIDX-1:0] LAST_IDX = WIDX'(WPB - 1);
   localparam logic [NBW-1:0]  FULL_NB  = NBW'(WB);

   state_t          state_q, state_d;
   logic [WIDX-1:0] wcnt_q, wcnt_d;
   logic            pend_q, pend_d;
   logic            final_q, final_d;
   logic            wr_en, clr, ld_extra;

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      pend_d   = pend_q;
      final_d  = final_q;
      wr_en    = 1'b0;
      clr      = 1'b0;
      ld_extra = 1'b0;
      case (state_q)
         FILL: begin
            if (i_valid) begin
               wr_en = 1'b1;
               if (!i_last) begin
                  if (wcnt_q == LAST_IDX) begin
                     state_d = EMIT;
                     final_d = 1'b0;
                  end else begin
                     wcnt_d = wcnt_q + 1'b1;
                  end
               end else begin
                  state_d = EMIT;
                  // A full last word that ends a block leaves all padding to an extra block.
                  if ((i_bytes == FULL_NB) && (wcnt_q == LAST_IDX)) begin
                     final_d = 1'b0;
                     pend_d  = 1'b1;
                  end else begin
                     final_d = 1'b1;
                  end
               end
            end
         end
         EMIT: begin
            if (i_ready) begin
               if (pend_q) begin
                  ld_extra = 1'b1;
                  pend_d   = 1'b0;
                  final_d  = 1'b1;
                  state_d  = EXTRA;
               end else begin
                  clr     = 1'b1;
                  wcnt_d  = '0;
                  final_d = 1'b0;
                  state_d = FILL;
               end
            end
         end
         EXTRA: begin
            if (i_ready) begin
               clr     = 1'b1;
               wcnt_d  = '0;
               final_d = 1'b0;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= FILL;
         wcnt_q  <= '0;
         pend_q  <= 1'b0;
         final_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         pend_q  <= pend_d;
         final_q <= final_d;
      end
   end

   assign o_ready = (state_q == FILL);
   assign o_valid = (state_q != FILL);
   assign o_final = final_q;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      keccak_pad_lane #(
         .IN_W    (IN_W),
         .RATE    (RATE),
         .DS_BYTE (DS_BYTE)
      ) u_lane (
         .clk      (i_clk),
         .rst_n    (i_rst_n),
         .clr      (clr),
         .ld_extra (ld_extra),
         .wr_en    (wr_en),
         .wr_last  (i_last),
         .wr_idx   (wcnt_q),
         .wr_bytes (i_bytes),
         .wr_data  (i_data[c*IN_W +: IN_W]),
         .blk      (o_block[c*RATE +: RATE])
      );
   end

endmodule

// File: tb/tb_keccak_pad_packer.sv
// Bench for keccak_pad_packer: byte-level SHA-3 padding model, per-cycle
// block compare, directed corner cases and randomized messages.
module tb_keccak_pad_packer;

   localparam int         NUM_CH = 2;
   localparam int         IN_W   = 64;
   localparam int         RATE   = 1088;
   localparam int         WB     = 8;
   localparam int         RB     = 136;
   localparam int         BW     = 4;
   localparam logic [7:0] DS     = 8'h06;
   localparam int         BLK_W  = NUM_CH * RATE;
   localparam int         DAT_W  = NUM_CH * IN_W;

   logic             i_clk   = 1'b0;
   logic             i_rst_n = 1'b0;
   logic             i_valid = 1'b0;
   logic             i_last  = 1'b0;
   logic             i_ready = 1'b1;
   logic [BW-1:0]    i_bytes = '0;
   logic [DAT_W-1:0] i_data  = '0;
   logic             o_ready, o_valid, o_final;
   logic [BLK_W-1:0] o_block;

   always #5 i_clk = ~i_clk;

   keccak_pad_packer #(
      .NUM_CH(NUM_CH), .IN_W(IN_W), .RATE(RATE), .DS_BYTE(DS)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_last(i_last), .i_bytes(i_bytes), .i_data(i_data), .o_valid(o_valid),
      .i_ready(i_ready), .o_block(o_block), .o_final(o_final)
   );

   typedef struct packed {
      logic             fin;
      logic [BLK_W-1:0] blk;
   } exp_t;

   exp_t             exp_q[$];
   logic [BLK_W-1:0] cap_blk[$];
   logic             cap_fin[$];
   logic [7:0]       msg_q[$];   // byte p of channel c at p*NUM_CH + c
   logic [DAT_W-1:0] beat_q[$];
   int               n_checks = 0;
   int               n_fail   = 0;
   int               rdy_mode = 0;  // 0: always ready, 1: random, 2: manual

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [BLK_W-1:0] b, input int c, input int i);
      return b[c*RATE + i*8 +: 8];
   endfunction

   // Whole-message padding: M || DS || 0* || 0x80, split into RB-byte blocks.
   task automatic model_push();
      int         len, nblk, idx;
      logic [7:0] b;
      exp_t       e;
      len  = msg_q.size() / NUM_CH;
      nblk = len / RB + 1;
      for (int bi = 0; bi < nblk; bi++) begin
         e.blk = '0;
         e.fin = (bi == nblk - 1);
         for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < RB; i++) begin
               idx = bi * RB + i;
               b   = (idx < len) ? msg_q[idx*NUM_CH + c] : 8'h00;
               if (idx == len)          b = b | DS;
               if (idx == nblk * RB - 1) b = b | 8'h80;
               e.blk[c*RATE + i*8 +: 8] = b;
            end
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_beat(input logic [DAT_W-1:0] d, input bit last, input int nb, input int max_gap);
      int n   = 0;
      bit acc = 1'b0;
      i_valid = 1'b1;
      i_data  = d;
      i_last  = last;
      i_bytes = nb[BW-1:0];
      while (!acc && n < 300) begin
         @(negedge i_clk);
         acc = o_ready;
         @(posedge i_clk);
         #1;
         n++;
      end
      if (!acc) check("beat_accept_timeout", 64'd0, 64'd1);
      i_valid = 1'b0;
      i_last  = 1'b0;
      repeat ($urandom_range(0, max_gap)) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic send_msg(input int nfull, input int nb, input bit with_last, input bit fixed,
                           input logic [DAT_W-1:0] fixed_data, input int max_gap);
      logic [DAT_W-1:0] d;
      int               nbeats;
      msg_q.delete();
      beat_q.delete();
      nbeats = nfull + (with_last ? 1 : 0);
      for (int k = 0; k < nbeats; k++) begin
         for (int j = 0; j < DAT_W / 32; j++) d[j*32 +: 32] = $urandom;
         if (fixed && k == nfull) d = fixed_data;
         beat_q.push_back(d);
         for (int i = 0; i < ((k == nfull) ? nb : WB); i++)
            for (int c = 0; c < NUM_CH; c++) msg_q.push_back(d[c*IN_W + i*8 +: 8]);
      end
      if (with_last) model_push();
      foreach (beat_q[k])
         drive_beat(beat_q[k], with_last && (k == nfull),
                    (k == nfull) ? nb : int'($urandom_range(0, WB)), max_gap);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || o_valid) && n < 2000) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      check("drain_timeout", 64'(n < 2000), 64'd1);
   endtask

   initial forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
         0:       i_ready = 1'b1;
         1:       i_ready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   end

   // Per-cycle compare: handshake relation, hold under backpressure, block contents.
   bit               pv = 1'b0, pt = 1'b0;
   logic [BLK_W-1:0] pb;
   logic             pf;
   exp_t             me;
   initial forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
         pv = 1'b0;
      end else begin
         check("ready_is_not_valid", 64'(o_ready), 64'(!o_valid));
         if (o_valid && pv && !pt) begin
            check("hold_block", 64'(o_block === pb), 64'd1);
            check("hold_final", 64'(o_final), 64'(pf));
         end
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_block", 64'd1, 64'd0);
            end else begin
               me = exp_q.pop_front();
               for (int c = 0; c < NUM_CH; c++)
                  for (int w = 0; w < RATE / IN_W; w++)
                     check($sformatf("blk_ch%0d_w%0d", c, w),
                           o_block[c*RATE + w*IN_W +: IN_W], me.blk[c*RATE + w*IN_W +: IN_W]);
               check("final_flag", 64'(o_final), 64'(me.fin));
            end
            cap_blk.push_back(o_block);
            cap_fin.push_back(o_final);
         end
         pv = o_valid;
         pt = o_valid && i_ready;
         pb = o_block;
         pf = o_final;
      end
   end

   logic [BLK_W-1:0] lit_empty;
   logic [BLK_W-1:0] bp_blk;
   logic [DAT_W-1:0] fd;
   int               nc;

   initial begin
      lit_empty = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         lit_empty[c*RATE +: 8]          = 8'h06;
         lit_empty[c*RATE + RATE-8 +: 8] = 8'h80;
      end

      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("reset_valid", 64'(o_valid), 64'd0);
      check("reset_final", 64'(o_final), 64'd0);
      check("reset_ready", 64'(o_ready), 64'd1);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;

      // Empty message
      nc = cap_blk.size();
      send_msg(0, 0, 1'b1, 1'b0, '0, 0);
      wait_drain();
      check("empty_count", 64'(cap_blk.size() - nc), 64'd1);
      check("empty_final", 64'(cap_fin[nc]), 64'd1);
      check("empty_ch0_b0", 64'(byte_of(cap_blk[nc], 0, 0)), 64'h06);
      check("empty_ch1_b135", 64'(byte_of(cap_blk[nc], 1, 135)), 64'h80);
      check("empty_whole", 64'(cap_blk[nc] === lit_empty), 64'd1);

      // "abc" / "xy" with three valid bytes; upper bytes carry garbage
      fd = '0;
      fd[63:0]   = {40'($urandom) | 40'h1, 24'h636261};
      fd[127:64] = {40'($urandom) | 40'h1, 24'h007978};
      nc = cap_blk.size();
      send_msg(0, 3, 1'b1, 1'b1, fd, 0);
      wait_drain();
      check("abc_ch0", 64'(cap_blk[nc][31:0]), 64'h06636261);
      check("abc_ch0_b135", 64'(byte_of(cap_blk[nc], 0, 135)), 64'h80);
      check("xy_ch1", 64'(cap_blk[nc][RATE +: 32]), 64'h06007978);
      check("abc_ch0_w0", cap_blk[nc][63:0], 64'h0000000006636261);

      // 135 bytes: domain byte and end bit share the last byte
      nc = cap_blk.size();
      send_msg(16, 7, 1'b1, 1'b0, '0, 1);
      wait_drain();
      check("m135_count", 64'(cap_blk.size() - nc), 64'd1);
      check("m135_final", 64'(cap_fin[nc]), 64'd1);
      check("m135_ch0_b135", 64'(byte_of(cap_blk[nc], 0, 135)), 64'h86);
      check("m135_ch1_b135", 64'(byte_of(cap_blk[nc], 1, 135)), 64'h86);

      // 136 bytes: full data block, then a padding-only block
      nc = cap_blk.size();
      send_msg(16, 8, 1'b1, 1'b0, '0, 0);
      wait_drain();
      check("m136_count", 64'(cap_blk.size() - nc), 64'd2);
      check("m136_first_final", 64'(cap_fin[nc]), 64'd0);
      check("m136_second_final", 64'(cap_fin[nc+1]), 64'd1);
      check("m136_second_whole", 64'(cap_blk[nc+1] === lit_empty), 64'd1);

      // Backpressure in EMIT with a beat offered
      rdy_mode = 2;
      i_ready  = 1'b0;
      nc       = cap_blk.size();
      send_msg(0, 0, 1'b1, 1'b0, '0, 0);
      i_valid = 1'b1;
      i_last  = 1'b0;
      i_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge i_clk);
      bp_blk = o_block;
      repeat (5) begin
         @(negedge i_clk);
         check("bp_valid", 64'(o_valid), 64'd1);
         check("bp_ready", 64'(o_ready), 64'd0);
         check("bp_stable", 64'(o_block === bp_blk), 64'd1);
      end
      @(posedge i_clk);
      #1;
      i_ready = 1'b1;
      i_valid = 1'b0;
      @(negedge i_clk);
      @(posedge i_clk);
      @(negedge i_clk);
      check("bp_release_ready", 64'(o_ready), 64'd1);
      check("bp_count", 64'(cap_blk.size() - nc), 64'd1);
      rdy_mode = 0;
      @(posedge i_clk);
      #1;

      // Reset in the middle of a block
      send_msg(5, 0, 1'b0, 1'b0, '0, 0);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      check("rst_mid_valid", 64'(o_valid), 64'd0);
      check("rst_mid_final", 64'(o_final), 64'd0);
      check("rst_mid_ready", 64'(o_ready), 64'd1);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      nc = cap_blk.size();
      send_msg(0, 0, 1'b1, 1'b0, '0, 0);
      wait_drain();
      check("rst_empty_count", 64'(cap_blk.size() - nc), 64'd1);
      check("rst_empty_whole", 64'(cap_blk[nc] === lit_empty), 64'd1);

      // Randomized messages under random backpressure
      rdy_mode = 1;
      for (int m = 0; m < 25; m++)
         send_msg($urandom_range(0, 40), $urandom_range(0, WB), 1'b1, 1'b0, '0, 2);
      rdy_mode = 0;
      wait_drain();
      check("model_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/keccak_pad_packer.md
# keccak_pad_packer

Parametrised multi-channel message front end for the Keccak core. It accepts word-serial message beats on a ready/valid/last handshake and packs each channel's beats into rate-sized blocks. It applies SHA-3 multi-rate padding (domain byte + pad10*1) on the final beat and emits complete blocks to the permutation stage under downstream backpressure. All channels share one handshake and one byte count; each channel has its own data path.

## Interface
- NUM_CH, 2, number of parallel message channels (≥1)
- IN_W, 64, input beat width per channel in bits; multiple of 8
- RATE, 1088, Keccak rate in bits; RATE % IN_W == 0 (WPB = RATE/IN_W words per block, WB = IN_W/8 bytes per word)
- DS_BYTE, 8'h06, domain-separation byte (8'h06 SHA-3, 8'h1F SHAKE)

- i_clk  in  1  single clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  block accepts a beat this cycle
- i_last  in  1  beat is the final beat of the message
- i_bytes  in  $clog2(WB)+1  valid bytes on a last beat (0..WB); ignored when i_last=0 (full word)
- i_data  in  NUM_CH*IN_W  channel c in bits [c*IN_W +: IN_W]; byte 0 = bits [7:0]
- o_valid  out  1  block valid
- i_ready  in  1  downstream accepts block
- o_block  out  NUM_CH*RATE  channel c in bits [c*RATE +: RATE]; word k in bits [k*IN_W +: IN_W]
- o_final  out  1  block is the last block of the message

## Operation
- States: FILL, EMIT, EXTRA. Reset: state=FILL, wcnt=0, all buffers=0, o_valid=0, o_final=0, so o_ready=1.
- o_ready = (state==FILL), combinational from state only.
- FILL, beat accepted (i_valid&o_ready), i_last=0: write word wcnt, wcnt++; if wcnt was WPB-1, go to EMIT with final=0.
- FILL, beat accepted, i_last=1, nb=i_bytes:
  - write bytes 0..nb-1 of word wcnt; bytes ≥nb are zero.
  - if nb<WB: OR DS_BYTE into byte nb of word wcnt.
  - if nb==WB and wcnt<WPB-1: OR DS_BYTE into byte 0 of word wcnt+1.
  - OR 8'h80 into byte WB-1 of word WPB-1, then go to EMIT with final=1.
  - Exception: nb==WB and wcnt==WPB-1 sets no pad bits. Go to EMIT with final=0 and a pending-extra flag.
- EMIT: o_valid=1, o_block/o_final held stable. On i_ready:
  - if pending-extra is set, go to EXTRA with the buffer loaded as all-zero, DS_BYTE at byte 0, 8'h80 ORed at the last byte (0x86 overlap if RATE==8 bits is impossible; RATE≥IN_W).
  - otherwise clear the buffer, set wcnt=0 and go to FILL.
- EXTRA: identical to EMIT with o_final=1; on i_ready clear the buffer, wcnt=0, go to FILL.
- Unused bytes are always zero because the buffer is cleared on every block start.
- All channels are written identically from their own i_data slice.
- i_valid while o_ready=0 is ignored. i_data/i_bytes/i_last are don't-care when i_valid=0.
- Reset asserted mid-block discards the partial block and the pending output.

## Timing
- Beat that completes a block (WPB-th beat, or the last beat) → o_valid=1 on the next rising edge.
- o_valid stays high until the cycle i_ready=1. The block is consumed on that edge, and o_ready=1 from the following cycle (FILL) or EXTRA o_valid=1 from the following cycle.
- No beat is accepted in EMIT/EXTRA. Throughput is WPB beats + 1 cycle per block minimum.
- o_block, o_final, o_valid are registered outputs; no combinational input→output path except none (o_ready depends on state only).

## Structure
- keccak_pkg: state enum (FILL/EMIT/EXTRA), PAD_END=8'h80, default DS constants (DS_SHA3=8'h06, DS_SHAKE=8'h1F), localparam helpers for WPB/WB.
- Sub-module keccak_pad_lane: one channel's RATE-bit buffer, word write with byte mask, and DS/0x80 OR logic. It is instantiated NUM_CH times by generate, driven by the shared FSM, wcnt and nb.

## Test plan
All scenarios use defaults: NUM_CH=2, IN_W=64, RATE=1088, WPB=17, WB=8, and i_ready=1 unless stated.
- Empty message: one beat i_last=1, i_bytes=0 → one block, o_final=1, byte0=0x06, byte135=0x80, all other bytes 0, both channels.
- "abc" on ch0 (i_data[63:0]=64'h636261), "xy" on ch1 with i_bytes=3 → ch0 bytes0-3 = 61 62 63 06, byte135=0x80, and ch1 bytes 0-2 = 78 79 00, byte3=0x06.
- 135-byte message (16 full beats, last i_bytes=7) → single block, o_final=1, byte135=0x86.
- 136-byte message (17 full beats, last i_bytes=8) → block 1 with o_final=0 and no pad bits, then block 2 with o_final=1, byte0=0x06, byte135=0x80, the rest 0.
- Backpressure: hold i_ready=0 for 5 cycles in EMIT with i_valid=1 → o_valid=1, o_block constant, o_ready=0, no beat consumed; release → o_ready=1 next cycle.
- Reset pulse after 5 beats → o_valid=0, o_final=0, o_ready=1; a following empty message yields the same block as the first scenario.
